// File: rtl/apb_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : apb_bridge_pkg                                                   |
// | Shared command/response layouts and FSM states for the AXI2APB bridge.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package apb_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [2:0]        prot;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              slverr;
        logic              timeout;
    } rsp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int CMD_W = $bits(cmd_t);
    localparam int RSP_W = $bits(rsp_t);

endpackage
`default_nettype wire

// File: rtl/apb_req_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : apb_req_engine                                                   |
// | Pops one bridge command, runs one APB4 transfer, pushes one response.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module apb_req_engine
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int TIMEOUT_LG2 = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         cmd_empty_i,
    output logic                                         cmd_rden_o,
    input  logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8+3:0] cmd_rdata_i,
    input  logic                                         rsp_full_i,
    output logic                                         rsp_wren_o,
    output logic [DATA_WIDTH+1:0]                        rsp_wdata_o,
    output logic                                         psel_o,
    output logic                                         penable_o,
    output logic                                         pwrite_o,
    output logic [ADDR_WIDTH-1:0]                        paddr_o,
    output logic [DATA_WIDTH-1:0]                        pwdata_o,
    output logic [DATA_WIDTH/8-1:0]                      pstrb_o,
    output logic [2:0]                                   pprot_o,
    input  logic [DATA_WIDTH-1:0]                        prdata_i,
    input  logic                                         pready_i,
    input  logic                                         pslverr_i,
    output logic                                         busy_o
);

    localparam int STRB_WL = DATA_WIDTH / 8;
    localparam int CMD_WL  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WL + 3;
    localparam int CNT_W   = (TIMEOUT_LG2 > 0) ? TIMEOUT_LG2 : 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    psel_q, penable_q, pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_WL-1:0]      pstrb_q;
    logic [2:0]              pprot_q;

    logic                    w_cmd_write;
    logic                    w_timeout;
    logic [DATA_WIDTH-1:0]   w_rdata;

    assign w_cmd_write = cmd_rdata_i[CMD_WL-1];
    assign w_timeout   = (TIMEOUT_LG2 != 0) && (cnt_q == {CNT_W{1'b1}});
    assign w_rdata     = pwrite_q ? {DATA_WIDTH{1'b0}} : prdata_i;

    // Pulses are gated by rst_n so a transfer cut by reset never pops or pushes.
    always_comb begin
        state_d     = state_q;
        cmd_rden_o  = 1'b0;
        rsp_wren_o  = 1'b0;
        rsp_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (!cmd_empty_i && !rsp_full_i) begin
                    cmd_rden_o = rst_n;
                    state_d    = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready_i) begin
                    rsp_wren_o  = rst_n;
                    rsp_wdata_o = {w_rdata, pslverr_i, 1'b0};
                    state_d     = IDLE;
                end else if (w_timeout) begin
                    rsp_wren_o  = rst_n;
                    rsp_wdata_o = {{DATA_WIDTH{1'b0}}, 2'b11};
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (state_d == SETUP) begin
                        psel_q   <= 1'b1;
                        pwrite_q <= w_cmd_write;
                        paddr_q  <= cmd_rdata_i[CMD_WL-2 -: ADDR_WIDTH];
                        pwdata_q <= cmd_rdata_i[3+STRB_WL +: DATA_WIDTH];
                        pstrb_q  <= w_cmd_write ? cmd_rdata_i[3 +: STRB_WL] : '0;
                        pprot_q  <= cmd_rdata_i[2:0];
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ACCESS: begin
                    if (state_d == IDLE) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                    end else if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = pwrite_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign pstrb_o   = pstrb_q;
    assign pprot_o   = pprot_q;
    assign busy_o    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_apb_req_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_apb_req_engine                                                |
// | Transaction-timeline model of the APB request engine with a random slave.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_apb_req_engine;
    import apb_bridge_pkg::*;

    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_empty_i = 1'b1;
    logic              cmd_rden_o;
    logic [CMD_W-1:0]  cmd_rdata_i = '0;
    logic              rsp_full_i = 1'b0;
    logic              rsp_wren_o;
    logic [RSP_W-1:0]  rsp_wdata_o;
    logic              psel_o, penable_o, pwrite_o;
    logic [31:0]       paddr_o, pwdata_o;
    logic [3:0]        pstrb_o;
    logic [2:0]        pprot_o;
    logic [31:0]       prdata_i = '0;
    logic              pready_i = 1'b0;
    logic              pslverr_i = 1'b0;
    logic              busy_o;

    apb_req_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_LG2(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_empty_i(cmd_empty_i), .cmd_rden_o(cmd_rden_o), .cmd_rdata_i(cmd_rdata_i),
        .rsp_full_i(rsp_full_i), .rsp_wren_o(rsp_wren_o), .rsp_wdata_o(rsp_wdata_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pending commands with the slave behaviour attached to each one.
    cmd_t        cq[$];
    int          wq[$];
    bit          eq[$];
    logic [31:0] dq[$];

    // k: -1 idle, 1 SETUP cycle, k>=2 ACCESS cycle number k-2
    int          k = -1;
    cmd_t        cur;
    int          curw;
    bit          cure;
    logic [31:0] curd;
    bit          full_req = 1'b0;
    bit          rst_req  = 1'b1;

    int          cyc = 0;
    int          psel_cnt = 0;
    int          pushes = 0;
    int          pops = 0;
    logic [33:0] rsp_log[$];
    int          push_cyc[$];
    int          pop_cyc[$];

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [33:0] last_rsp();
        return (rsp_log.size() > 0) ? rsp_log[rsp_log.size()-1] : '1;
    endfunction

    task automatic push_cmd(input bit wr, input logic [31:0] ad, input logic [31:0] wd,
                            input logic [3:0] st, input logic [2:0] pr,
                            input int w, input bit e, input logic [31:0] rd);
        cmd_t c;
        c.write = wr;
        c.addr  = ad;
        c.wdata = wd;
        c.strb  = st;
        c.prot  = pr;
        cq.push_back(c);
        wq.push_back(w);
        eq.push_back(e);
        dq.push_back(rd);
    endtask

    task automatic step();
        bit          exp_rden, exp_wren, done, rdy_now;
        logic [33:0] exp_rsp;
        int          a;
        @(negedge clk);
        rst_n       = !rst_req;
        cmd_empty_i = (cq.size() == 0);
        cmd_rdata_i = cmd_empty_i ? CMD_W'({$urandom(), $urandom(), $urandom()}) : cq[0];
        rsp_full_i  = (k >= 2) ? 1'b0 : full_req;
        a           = k - 2;
        rdy_now     = (k >= 2) && (curw < TO) && (a == curw);
        pready_i    = (k >= 2) ? rdy_now : 1'($urandom_range(0, 1));
        prdata_i    = rdy_now ? curd : $urandom();
        pslverr_i   = rdy_now ? cure : 1'($urandom_range(0, 1));
        #1;
        done     = (k >= 2) && ((curw < TO) ? (a == curw) : (a == TO - 1));
        exp_rden = !rst_req && (k == -1) && !cmd_empty_i && !rsp_full_i;
        exp_wren = !rst_req && done;
        chk("rden", 72'(cmd_rden_o), 72'(exp_rden));
        chk("wren", 72'(rsp_wren_o), 72'(exp_wren));
        if (exp_wren) begin
            exp_rsp = (curw < TO) ? {(cur.write ? 32'h0 : curd), cure, 1'b0} : {32'h0, 2'b11};
            chk("rsp_data", 72'(rsp_wdata_o), 72'(exp_rsp));
        end
        if (!rst_req) begin
            chk("psel", 72'(psel_o), 72'(k >= 1));
            chk("penable", 72'(penable_o), 72'(k >= 2));
            chk("busy", 72'(busy_o), 72'(k >= 1));
            if (k >= 1) begin
                chk("pwrite", 72'(pwrite_o), 72'(cur.write));
                chk("paddr", 72'(paddr_o), 72'(cur.addr));
                chk("pwdata", 72'(pwdata_o), 72'(cur.wdata));
                chk("pstrb", 72'(pstrb_o), 72'(cur.write ? cur.strb : 4'h0));
                chk("pprot", 72'(pprot_o), 72'(cur.prot));
            end
        end
        if (psel_o === 1'b1) psel_cnt++;
        if (rsp_wren_o === 1'b1) begin
            pushes++;
            rsp_log.push_back(rsp_wdata_o);
            push_cyc.push_back(cyc);
        end
        if (cmd_rden_o === 1'b1) begin
            pops++;
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (rst_req) begin
            k = -1;
        end else if (exp_rden) begin
            cur  = cq.pop_front();
            curw = wq.pop_front();
            cure = eq.pop_front();
            curd = dq.pop_front();
            k    = 1;
        end else if (k >= 1) begin
            k = done ? -1 : k + 1;
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((k != -1 || cq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", 72'(n < budget), 72'(1));
    endtask

    initial begin
        int p0, q0, c0, n;
        logic [31:0] r1, r2;

        // Reset state
        repeat (3) step();
        chk("rst_paddr", 72'(paddr_o), 72'(0));
        chk("rst_pwdata", 72'(pwdata_o), 72'(0));
        chk("rst_pstrb", 72'(pstrb_o), 72'(0));
        chk("rst_pprot", 72'(pprot_o), 72'(0));
        chk("rst_pwrite", 72'(pwrite_o), 72'(0));
        chk("rst_psel", 72'(psel_o), 72'(0));
        chk("rst_busy", 72'(busy_o), 72'(0));
        rst_req = 1'b0;
        repeat (2) step();

        // Single read, ready in first ACCESS
        psel_cnt = 0; p0 = pushes; q0 = pops;
        push_cmd(1'b0, 32'h40, 32'h0, 4'h0, 3'h0, 0, 1'b0, 32'hCAFE0001);
        drain(50);
        chk("read_rsp", 72'(last_rsp()), 72'({32'hCAFE0001, 2'b00}));
        chk("read_psel_cycles", 72'(psel_cnt), 72'(2));
        chk("read_pushes", 72'(pushes - p0), 72'(1));
        chk("read_pops", 72'(pops - q0), 72'(1));

        // Write with 3 wait states
        psel_cnt = 0;
        push_cmd(1'b1, 32'h80, 32'h12345678, 4'b0101, 3'h0, 3, 1'b0, $urandom());
        drain(50);
        chk("write_rsp", 72'(last_rsp()), 72'(0));
        chk("write_psel_cycles", 72'(psel_cnt), 72'(5));

        // PSLVERR read followed by a queued read
        r1 = 32'h1111_2222; r2 = 32'h3333_4444;
        push_cmd(1'b0, 32'h100, 32'h0, 4'h0, 3'h5, 1, 1'b1, r1);
        push_cmd(1'b0, 32'h104, 32'h0, 4'h0, 3'h2, 0, 1'b0, r2);
        drain(50);
        chk("slverr_rsp", 72'(rsp_log[rsp_log.size()-2]), 72'({r1, 2'b10}));
        chk("after_err_rsp", 72'(last_rsp()), 72'({r2, 2'b00}));
        chk("reissue_gap", 72'(pop_cyc[pop_cyc.size()-1] - push_cyc[push_cyc.size()-2]), 72'(1));

        // Hung slave: timeout after 16 ACCESS cycles
        psel_cnt = 0;
        push_cmd(1'b0, 32'h200, 32'h0, 4'h0, 3'h0, 1000, 1'b0, 32'h0);
        drain(60);
        chk("timeout_rsp", 72'(last_rsp()), 72'({32'h0, 2'b11}));
        chk("timeout_psel_cycles", 72'(psel_cnt), 72'(17));

        // Response FIFO full blocks issue; release gives back-to-back transfers
        full_req = 1'b1; psel_cnt = 0; q0 = pops; p0 = pushes;
        push_cmd(1'b0, 32'h300, 32'h0, 4'h0, 3'h0, 0, 1'b0, 32'hA0A0_0001);
        push_cmd(1'b1, 32'h304, 32'h5555_AAAA, 4'hF, 3'h1, 0, 1'b0, 32'h0);
        push_cmd(1'b0, 32'h308, 32'h0, 4'h0, 3'h0, 0, 1'b0, 32'hA0A0_0003);
        repeat (5) step();
        chk("full_no_pop", 72'(pops - q0), 72'(0));
        chk("full_no_psel", 72'(psel_cnt), 72'(0));
        full_req = 1'b0;
        c0 = cyc;
        drain(50);
        chk("b2b_pushes", 72'(pushes - p0), 72'(3));
        chk("b2b_span", 72'(push_cyc[push_cyc.size()-1] - c0 + 1), 72'(9));
        chk("b2b_order0", 72'(rsp_log[rsp_log.size()-3]), 72'({32'hA0A0_0001, 2'b00}));
        chk("b2b_order2", 72'(last_rsp()), 72'({32'hA0A0_0003, 2'b00}));

        // Reset during ACCESS
        p0 = pushes;
        push_cmd(1'b0, 32'h400, 32'h0, 4'h0, 3'h0, 10, 1'b0, 32'h0);
        n = 0;
        while (k < 4 && n < 20) begin
            step();
            n++;
        end
        chk("reach_access", 72'(k >= 4), 72'(1));
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        chk("rst_mid_no_push", 72'(pushes - p0), 72'(0));
        push_cmd(1'b0, 32'h404, 32'h0, 4'h0, 3'h0, 0, 1'b0, 32'h0BAD_F00D);
        drain(50);
        chk("restart_rsp", 72'(last_rsp()), 72'({32'h0BAD_F00D, 2'b00}));

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0 && cq.size() < 3) begin
                int r, w;
                r = $urandom_range(0, 9);
                if (r < 7)      w = $urandom_range(0, 3);
                else if (r < 9) w = $urandom_range(4, 15);
                else            w = 1000;
                push_cmd(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                         4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                         w, 1'($urandom_range(0, 1)), $urandom());
            end
            full_req = ($urandom_range(0, 4) == 0);
            rst_req  = ($urandom_range(0, 199) == 0);
            step();
        end
        full_req = 1'b0;
        rst_req  = 1'b0;
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
